// File: rtl/btb_pkg.sv
// Shared types and constants for the BTB update path: PC geometry, the
// training-record layout and the controller state encoding.
package btb_pkg;

    localparam int BTB_IDX_W = 6;
    localparam int BTB_TAG_W = 24;
    localparam int PC_W      = 32;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
        logic            taken;
    } upd_rec_t;

    localparam int UPD_REC_W = $bits(upd_rec_t);

    typedef enum logic {
        IDLE    = 1'b0,
        RECOVER = 1'b1
    } state_t;

    // Fall-through for not-taken branches wraps modulo 2^32.
    function automatic logic [PC_W-1:0] redirect_of(input logic [PC_W-1:0] pc,
                                                    input logic [PC_W-1:0] target,
                                                    input logic            taken);
        return taken ? target : (pc + 32'd4);
    endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Generic synchronous FIFO with extra-MSB pointers; push while full is
// accepted when the same cycle pops, since the popped slot is the one written.
module btb_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage holds data only; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// Branch-resolution controller: mispredict detection, flush/redirect,
// wrong-path squash window and queued BTB training updates.
import btb_pkg::*;

module btb_update_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int RECOVER_CYCLES = 3,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             res_valid,
    input  logic [31:0]      res_pc,
    input  logic [31:0]      res_target,
    input  logic             res_taken,
    input  logic             res_pred_taken,
    input  logic [31:0]      res_pred_target,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    input  logic             upd_ready,
    output logic             upd_valid,
    output logic [31:0]      upd_pc,
    output logic [31:0]      upd_target,
    output logic             upd_taken,
    output logic [CNT_W-1:0] mispredict_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int RC_W = (RECOVER_CYCLES < 1) ? 1 : $clog2(RECOVER_CYCLES + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [RC_W-1:0]  r_rcnt;
    logic             r_flush;
    logic [31:0]      r_redirect_pc;
    logic [CNT_W-1:0] r_mispredict_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    logic             w_accept;
    logic             w_mispredict;
    logic             w_flush_req;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_drop;
    upd_rec_t         w_rec;
    upd_rec_t         w_head;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_mispredict = (res_pred_taken != res_taken) ||
                          (res_taken && (res_pred_target != res_target));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_flush_req && (RECOVER_CYCLES > 0)) w_state_nxt = RECOVER;
            RECOVER: if (r_rcnt <= RC_W'(1))                  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // The !r_flush term only matters when there is no recovery window.
    always_comb begin
        w_accept    = res_valid && (r_state == IDLE) && !r_flush;
        w_flush_req = w_accept && w_mispredict;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rcnt <= '0;
        end else if (w_flush_req) begin
            r_rcnt <= RC_W'(RECOVER_CYCLES);
        end else if ((r_state == RECOVER) && (r_rcnt != '0)) begin
            r_rcnt <= r_rcnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush          <= 1'b0;
            r_redirect_pc    <= '0;
            r_mispredict_cnt <= '0;
            r_drop_cnt       <= '0;
        end else begin
            r_flush       <= w_flush_req;
            r_redirect_pc <= w_flush_req ? redirect_of(res_pc, res_target, res_taken) : '0;
            if (w_flush_req) r_mispredict_cnt <= sat_inc(r_mispredict_cnt);
            if (w_drop)      r_drop_cnt       <= sat_inc(r_drop_cnt);
        end
    end

    assign w_rec  = '{pc: res_pc, target: res_target, taken: res_taken};
    assign w_pop  = !w_empty && upd_ready;
    assign w_drop = w_accept && w_full && !w_pop;

    btb_upd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UPD_REC_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_accept),
        .i_pop   (w_pop),
        .i_data  (w_rec),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign flush          = r_flush;
    assign redirect_pc    = r_redirect_pc;
    assign mispredict_cnt = r_mispredict_cnt;
    assign drop_cnt       = r_drop_cnt;
    assign upd_valid      = !w_empty;
    assign upd_pc         = w_empty ? '0 : w_head.pc;
    assign upd_target     = w_empty ? '0 : w_head.target;
    assign upd_taken      = w_empty ? 1'b0 : w_head.taken;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: prediction hits, mispredicts, the
// squash window, FIFO overflow/drain order and mid-recovery reset.
module tb_btb_update_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        res_valid;
    logic [31:0] res_pc;
    logic [31:0] res_target;
    logic        res_taken;
    logic        res_pred_taken;
    logic [31:0] res_pred_target;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        upd_ready;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic [31:0] mispredict_cnt;
    logic [31:0] drop_cnt;

    int checks   = 0;
    int failures = 0;

    btb_update_ctrl #(
        .FIFO_DEPTH     (4),
        .RECOVER_CYCLES (3),
        .CNT_W          (32)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .res_valid       (res_valid),
        .res_pc          (res_pc),
        .res_target      (res_target),
        .res_taken       (res_taken),
        .res_pred_taken  (res_pred_taken),
        .res_pred_target (res_pred_target),
        .flush           (flush),
        .redirect_pc     (redirect_pc),
        .upd_ready       (upd_ready),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_target      (upd_target),
        .upd_taken       (upd_taken),
        .mispredict_cnt  (mispredict_cnt),
        .drop_cnt        (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                         input logic ptk, input logic [31:0] ptgt);
        res_valid       = 1'b1;
        res_pc          = pc;
        res_target      = tgt;
        res_taken       = tk;
        res_pred_taken  = ptk;
        res_pred_target = ptgt;
    endtask

    task automatic no_res();
        res_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        upd_ready = 1'b0;
        res_valid = 1'b0; res_pc = '0; res_target = '0; res_taken = 1'b0;
        res_pred_taken = 1'b0; res_pred_target = '0;
        #3;
        check("rst_flush", flush, 0);
        check("rst_redirect", redirect_pc, 0);
        check("rst_upd_valid", upd_valid, 0);
        check("rst_upd_pc", upd_pc, 0);
        check("rst_mcnt", mispredict_cnt, 0);
        check("rst_dcnt", drop_cnt, 0);
        #19 rst_n = 1'b1;

        // Correct prediction: no flush, update one cycle later
        drive(32'h100, 32'h200, 1'b1, 1'b1, 32'h200);
        tick();
        check("hit_flush", flush, 0);
        check("hit_upd_valid", upd_valid, 1);
        check("hit_upd_pc", upd_pc, 32'h100);
        check("hit_upd_target", upd_target, 32'h200);
        check("hit_upd_taken", upd_taken, 1);
        no_res();
        upd_ready = 1'b1;
        tick();
        check("hit_popped", upd_valid, 0);
        upd_ready = 1'b0;

        // Direction mispredict, then the squash window
        drive(32'h40, 32'h80, 1'b1, 1'b0, 32'h0);
        tick();
        check("dir_flush", flush, 1);
        check("dir_redirect", redirect_pc, 32'h80);
        check("dir_mcnt", mispredict_cnt, 1);
        for (int i = 0; i < 3; i++) begin
            drive(32'h44 + 32'(i * 4), 32'h999, 1'b1, 1'b0, 32'h0);
            tick();
            check($sformatf("squash_flush%0d", i), flush, 0);
        end
        no_res();
        check("squash_mcnt", mispredict_cnt, 1);
        check("squash_head", upd_pc, 32'h40);
        upd_ready = 1'b1;
        tick();
        check("squash_no_enq", upd_valid, 0);

        // Not-taken mispredicts: fall-through and wraparound
        drive(32'h1000, 32'h2000, 1'b0, 1'b1, 32'h2000);
        tick();
        check("nt_flush", flush, 1);
        check("nt_redirect", redirect_pc, 32'h1004);
        check("nt_mcnt", mispredict_cnt, 2);
        no_res();
        tick();
        check("no_consec_flush", flush, 0);
        tick(); tick();
        drive(32'hFFFF_FFFC, 32'h10, 1'b0, 1'b1, 32'h10);
        tick();
        check("wrap_flush", flush, 1);
        check("wrap_redirect", redirect_pc, 32'h0);
        no_res();
        tick(); tick(); tick();

        // Wrong-target mispredict
        drive(32'h500, 32'h340, 1'b1, 1'b1, 32'h300);
        tick();
        check("tgt_flush", flush, 1);
        check("tgt_redirect", redirect_pc, 32'h340);
        check("tgt_mcnt", mispredict_cnt, 4);
        no_res();
        tick(); tick(); tick();
        check("drained", upd_valid, 0);

        // Overflow with the BTB stalled, then in-order drain
        upd_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(32'(i * 16), 32'(i * 16 + 256), 1'b1, 1'b1, 32'(i * 16 + 256));
            tick();
        end
        no_res();
        check("ovf_dcnt", drop_cnt, 1);
        check("ovf_flush", flush, 0);
        check("ovf_head_target", upd_target, 32'h110);
        upd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("drain_valid%0d", i), upd_valid, 1);
            check($sformatf("drain_pc%0d", i), upd_pc, 32'(i * 16));
            tick();
        end
        check("drain_empty", upd_valid, 0);

        // Push and pop together while full: nothing dropped
        upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(32'hA0 + 32'(i * 16), 32'h0, 1'b0, 1'b0, 32'h0);
            tick();
        end
        check("full_head", upd_pc, 32'hA0);
        upd_ready = 1'b1;
        drive(32'hE0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        no_res();
        check("pp_dcnt", drop_cnt, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pp_pc%0d", i), upd_pc, 32'hB0 + 32'(i * 16));
            tick();
        end
        check("pp_empty", upd_valid, 0);

        // Reset during recovery with two entries queued
        upd_ready = 1'b0;
        drive(32'h600, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(32'h610, 32'h0, 1'b0, 1'b1, 32'h0);
        tick();
        check("pre_rst_flush", flush, 1);
        no_res();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_flush", flush, 0);
        check("mid_rst_redirect", redirect_pc, 0);
        check("mid_rst_upd_valid", upd_valid, 0);
        check("mid_rst_upd_pc", upd_pc, 0);
        check("mid_rst_mcnt", mispredict_cnt, 0);
        check("mid_rst_dcnt", drop_cnt, 0);
        #1 rst_n = 1'b1;
        drive(32'h700, 32'h780, 1'b1, 1'b0, 32'h0);
        tick();
        no_res();
        check("post_rst_flush", flush, 1);
        check("post_rst_redirect", redirect_pc, 32'h780);
        check("post_rst_mcnt", mispredict_cnt, 1);
        check("post_rst_upd_pc", upd_pc, 32'h700);
        tick();
        check("post_rst_flush_clr", flush, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
